// File: rtl/pc_out_depacker.sv
// pc_out_depacker: host-side receiver for the FPGA-to-PC upstream word stream.
// Each input word is {route, code, data}. Words not addressed to GO_HOME_RT are
// forwarded unchanged on the BD channel. GO_HOME_RT words are either spike-filter
// data (sf channel), heartbeat fragments reassembled into a 48-bit time value
// (time channel), or protocol errors that bump a saturating error counter.
// Every output channel is a one-entry register slice, so there is one cycle of
// latency and full throughput when downstream holds ready high.
//
// Configuration macro: PC_OUT_DEPACK_NOP_DROP_EN
//   defined   -> GO_HOME_RT words carrying CODE_NOP are silently dropped
//   undefined -> such words are treated as unknown codes (err_cnt += 1)
//
// Handshake (all channels): a transfer happens on a rising clk edge where both
// v and a are high. A producer keeps v high and its data stable until that edge.
module pc_out_depacker #(
    parameter int NPCcode     = 7,
    parameter int NPCdata     = 20,
    parameter int NPCroute    = 8,
    parameter int GO_HOME_RT  = 255,
    parameter int CODE_HB_LO  = 0,
    parameter int CODE_HB_MID = 1,
    parameter int CODE_HB_HI  = 2,
    parameter int CODE_SF     = 3,
    parameter int CODE_NOP    = 127,
    parameter int Nerr        = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NPCroute+NPCcode+NPCdata-1:0] in_d,
    input  logic                                in_v,
    output logic                                in_a,
    output logic [NPCroute+NPCcode+NPCdata-1:0] bd_d,
    output logic                                bd_v,
    input  logic                                bd_a,
    output logic [NPCdata-1:0]                  sf_d,
    output logic                                sf_v,
    input  logic                                sf_a,
    output logic [47:0]                         time_d,
    output logic                                time_v,
    input  logic                                time_a,
    output logic [Nerr-1:0]                     err_cnt,
    output logic [1:0]                          hb_state
);

    localparam int W = NPCroute + NPCcode + NPCdata;

    localparam logic [NPCroute-1:0] RT_HOME = NPCroute'(GO_HOME_RT);
    localparam logic [NPCcode-1:0]  C_LO    = NPCcode'(CODE_HB_LO);
    localparam logic [NPCcode-1:0]  C_MID   = NPCcode'(CODE_HB_MID);
    localparam logic [NPCcode-1:0]  C_HI    = NPCcode'(CODE_HB_HI);
    localparam logic [NPCcode-1:0]  C_SF    = NPCcode'(CODE_SF);
    localparam logic [NPCcode-1:0]  C_NOP   = NPCcode'(CODE_NOP);

`ifdef PC_OUT_DEPACK_NOP_DROP_EN
    localparam logic NOP_DROP = 1'b1;
`else
    localparam logic NOP_DROP = 1'b0;
`endif

    typedef enum logic [1:0] {
        HB_IDLE    = 2'd0,
        HB_GOT_LO  = 2'd1,
        HB_GOT_MID = 2'd2
    } hb_state_t;

    hb_state_t state, state_nxt;

    logic [NPCroute-1:0] w_route;
    logic [NPCcode-1:0]  w_code;
    logic [NPCdata-1:0]  w_data;

    logic is_home, go_bd, go_sf, is_lo, is_mid, is_hi, go_hb, is_nop;
    logic code_known, is_unknown;
    logic bd_free, sf_free, time_free;
    logic hb_emit_req, xfer, hb_xfer;
    logic hb_err, lo_load, mid_load, time_load, err_inc;

    logic [NPCdata-1:0] hb_lo, hb_mid;

    assign w_route = in_d[W-1 -: NPCroute];
    assign w_code  = in_d[NPCdata +: NPCcode];
    assign w_data  = in_d[NPCdata-1:0];

    // Word classification; the NOP code only counts as known when dropping is enabled.
    always_comb begin
        is_home    = (w_route == RT_HOME);
        go_bd      = !is_home;
        go_sf      = is_home && (w_code == C_SF);
        is_lo      = is_home && (w_code == C_LO);
        is_mid     = is_home && (w_code == C_MID);
        is_hi      = is_home && (w_code == C_HI);
        go_hb      = is_lo || is_mid || is_hi;
        is_nop     = is_home && (w_code == C_NOP);
        code_known = go_sf || go_hb || (is_nop && NOP_DROP);
        is_unknown = is_home && !code_known;
    end

    // Input acceptance: only the slice the word targets can stall it. The only
    // heartbeat word that needs a slice is HB_HI arriving in GOT_MID.
    always_comb begin
        bd_free     = !bd_v || bd_a;
        sf_free     = !sf_v || sf_a;
        time_free   = !time_v || time_a;
        hb_emit_req = is_hi && (state == HB_GOT_MID);
        if (go_bd)
            in_a = reset && bd_free;
        else if (go_sf)
            in_a = reset && sf_free;
        else if (hb_emit_req)
            in_a = reset && time_free;
        else
            in_a = reset;
        xfer    = in_v && in_a;
        hb_xfer = xfer && go_hb;
    end

    // Heartbeat FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HB_IDLE;
        else        state <= state_nxt;
    end

    // Heartbeat FSM next state and fragment-latch controls; only accepted HB words move it.
    always_comb begin
        state_nxt = state;
        hb_err    = 1'b0;
        lo_load   = 1'b0;
        mid_load  = 1'b0;
        time_load = 1'b0;
        if (hb_xfer) begin
            case (state)
                HB_IDLE: begin
                    if (is_lo) begin
                        lo_load   = 1'b1;
                        state_nxt = HB_GOT_LO;
                    end else begin
                        hb_err = 1'b1;
                    end
                end
                HB_GOT_LO: begin
                    if (is_mid) begin
                        mid_load  = 1'b1;
                        state_nxt = HB_GOT_MID;
                    end else if (is_lo) begin
                        hb_err  = 1'b1;
                        lo_load = 1'b1;
                    end else begin
                        hb_err    = 1'b1;
                        state_nxt = HB_IDLE;
                    end
                end
                HB_GOT_MID: begin
                    if (is_hi) begin
                        time_load = 1'b1;
                        state_nxt = HB_IDLE;
                    end else if (is_lo) begin
                        hb_err    = 1'b1;
                        lo_load   = 1'b1;
                        state_nxt = HB_GOT_LO;
                    end else begin
                        hb_err    = 1'b1;
                        state_nxt = HB_IDLE;
                    end
                end
                default: state_nxt = HB_IDLE;
            endcase
        end
        err_inc = (xfer && is_unknown) || hb_err;
    end

    assign hb_state = state;

    // Latch the low and middle heartbeat fragments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_lo  <= '0;
            hb_mid <= '0;
        end else begin
            if (lo_load)  hb_lo  <= w_data;
            if (mid_load) hb_mid <= w_data;
        end
    end

    // BD output slice: whole word forwarded unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_v <= 1'b0;
            bd_d <= '0;
        end else if (xfer && go_bd) begin
            bd_v <= 1'b1;
            bd_d <= in_d;
        end else if (bd_a) begin
            bd_v <= 1'b0;
        end
    end

    // Spike-filter output slice: data field only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sf_v <= 1'b0;
            sf_d <= '0;
        end else if (xfer && go_sf) begin
            sf_v <= 1'b1;
            sf_d <= w_data;
        end else if (sf_a) begin
            sf_v <= 1'b0;
        end
    end

    // Time output slice: {hi[7:0], mid, lo} loaded when HB_HI completes a sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_v <= 1'b0;
            time_d <= '0;
        end else if (time_load) begin
            time_v <= 1'b1;
            time_d <= {w_data[7:0], hb_mid, hb_lo};
        end else if (time_a) begin
            time_v <= 1'b0;
        end
    end

    // Saturating protocol-error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_cnt <= '0;
        else if (err_inc && (err_cnt != {Nerr{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule
